// File: rtl/div_pkg.sv
// Shared types for the divider request issuer: FSM states and the
// operand/result records that travel between the FIFO, the divider and the
// response port. The tag width is an instance parameter, so tags are carried
// alongside these records rather than inside them.
package div_pkg;

   localparam logic [15:0] Q4_12_ONE = 16'h1000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } div_state_t;

   typedef struct packed {
      logic [15:0] num;
      logic [15:0] den;
   } div_req_t;

   typedef struct packed {
      logic [15:0] quot;
      logic        err_div0;
      logic        err_timeout;
   } div_rsp_t;

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous FIFO holding pending division requests. A push is refused
// whenever the FIFO is full, even if a pop happens in the same cycle.
module div_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy guards every read
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/div_request_issuer.sv
// Front-end for the Q4.12 iterative divider: queues tagged requests, issues
// them one at a time, waits for the result (or a watchdog expiry) and returns
// tagged in-order responses.
module div_request_issuer
   import div_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_num,
   input  logic [15:0]      req_den,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_quot,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err_div0,
   output logic             rsp_err_timeout,
   output logic             div_start,
   output logic [15:0]      div_num,
   output logic [15:0]      div_den,
   input  logic [15:0]      div_quot,
   input  logic             div_valid,
   input  logic             div_error,
   output logic             busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int FW = 32 + TAG_W;

   div_state_t       state;
   div_state_t       next_state;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [FW-1:0]    fifo_wdata;
   logic [FW-1:0]    fifo_rdata;
   div_req_t         head_op;
   logic [TAG_W-1:0] head_tag;
   logic             issue;
   logic [TW-1:0]    timer;
   logic             timer_expired;
   div_req_t         issued_op;
   logic [TAG_W-1:0] issued_tag;
   div_rsp_t         result;

   assign req_ready          = !fifo_full;
   assign fifo_wdata         = {req_tag, req_num, req_den};
   assign {head_tag, head_op} = fifo_rdata;
   assign timer_expired      = (timer == TW'(TIMEOUT));

   div_req_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next state: a result or the watchdog ends WAIT, a consumed response ends RESP
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!fifo_empty) next_state = WAIT;
         WAIT:    if (div_valid || timer_expired) next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Control outputs decoded from the current state
   always_comb begin
      issue     = 1'b0;
      fifo_pop  = 1'b0;
      rsp_valid = 1'b0;
      busy      = !fifo_empty || (state != IDLE);
      case (state)
         IDLE: begin
            issue    = !fifo_empty;
            fifo_pop = !fifo_empty;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: latch the issued operands, run the watchdog, capture the outcome
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_start  <= 1'b0;
         issued_op  <= '0;
         issued_tag <= '0;
         timer      <= '0;
         result     <= '0;
      end else begin
         div_start <= issue;
         if (issue) begin
            issued_op  <= head_op;
            issued_tag <= head_tag;
            timer      <= '0;
         end else if (state == WAIT) begin
            timer <= timer + TW'(1);
            if (div_valid) begin
               result <= '{quot: div_quot, err_div0: div_error, err_timeout: 1'b0};
            end else if (timer_expired) begin
               result <= '{quot: 16'h0000, err_div0: 1'b0, err_timeout: 1'b1};
            end
         end
      end
   end

   assign div_num         = issued_op.num;
   assign div_den         = issued_op.den;
   assign rsp_quot        = result.quot;
   assign rsp_tag         = issued_tag;
   assign rsp_err_div0    = result.err_div0;
   assign rsp_err_timeout = result.err_timeout;

endmodule

// File: tb/tb_div_request_issuer.sv
// Randomized scoreboard bench for div_request_issuer with a behavioural divider
// model whose latency (or silence) is chosen per request.
module tb_div_request_issuer;
   import div_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [15:0]      req_num = '0;
   logic [15:0]      req_den = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [15:0]      rsp_quot;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err_div0;
   logic             rsp_err_timeout;
   logic             div_start;
   logic [15:0]      div_num;
   logic [15:0]      div_den;
   logic [15:0]      div_quot = '0;
   logic             div_valid = 1'b0;
   logic             div_error = 1'b0;
   logic             busy;

   div_request_issuer #(
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_num         (req_num),
      .req_den         (req_den),
      .req_tag         (req_tag),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_quot        (rsp_quot),
      .rsp_tag         (rsp_tag),
      .rsp_err_div0    (rsp_err_div0),
      .rsp_err_timeout (rsp_err_timeout),
      .div_start       (div_start),
      .div_num         (div_num),
      .div_den         (div_den),
      .div_quot        (div_quot),
      .div_valid       (div_valid),
      .div_error       (div_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]      quot;
      logic [TAG_W-1:0] tag;
      logic             e0;
      logic             et;
   } exp_t;

   exp_t        expQ[$];
   int          latQ[$];
   logic [31:0] opQ[$];
   int          riseQ[$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   logic randReady = 1'b0;

   // Free-running cycle count used to time responses against div_start
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      compared++;
      if (actual !== required) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
      end
   endtask

   function automatic logic [15:0] divQuot(input logic [15:0] num, input logic [15:0] den);
      longint q;
      if (den == 16'h0000) return 16'h0000;
      q = (longint'(num) * 4096) / longint'(den);
      return q[15:0];
   endfunction

   function automatic bit respondsInTime(input int lat);
      return (lat >= 1) && (lat <= TIMEOUT);
   endfunction

   function automatic exp_t modelResponse(input logic [15:0] num, input logic [15:0] den,
                                          input logic [TAG_W-1:0] tag, input int lat);
      exp_t e;
      e.tag  = tag;
      e.quot = 16'h0000;
      e.e0   = 1'b0;
      e.et   = 1'b0;
      if (!respondsInTime(lat))   e.et = 1'b1;
      else if (den == 16'h0000)   e.e0 = 1'b1;
      else                        e.quot = divQuot(num, den);
      return e;
   endfunction

   task automatic enqueue(input logic [15:0] num, input logic [15:0] den,
                          input logic [TAG_W-1:0] tag, input int lat);
      expQ.push_back(modelResponse(num, den, tag, lat));
      latQ.push_back(lat);
      opQ.push_back({num, den});
   endtask

   // Offer one request and hold it until accepted; lat 0 means the divider never answers
   task automatic applyStimulus(input logic [15:0] num, input logic [15:0] den,
                                input logic [TAG_W-1:0] tag, input int lat);
      int  waited = 0;
      bit  done   = 0;
      req_num   = num;
      req_den   = den;
      req_tag   = tag;
      req_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (req_ready) begin
            enqueue(num, den, tag, lat);
            done = 1;
         end else if (++waited > 200) begin
            checkOutput("req_accept_timeout", 64'd0, 64'd1);
            done = 1;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDrained(input string name);
      int n = 0;
      while (expQ.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_drain_left"}, 64'(expQ.size()), 64'd0);
      checkOutput({name, "_busy_after_drain"}, 64'(busy), 64'd0);
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, "_req_ready"}, 64'(req_ready), 64'd1);
      checkOutput({name, "_busy"}, 64'(busy), 64'd0);
      checkOutput({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      checkOutput({name, "_div_start"}, 64'(div_start), 64'd0);
      checkOutput({name, "_div_operands"}, 64'({div_num, div_den}), 64'd0);
      checkOutput({name, "_rsp_fields"},
                  64'({rsp_quot, rsp_tag, rsp_err_div0, rsp_err_timeout}), 64'd0);
   endtask

   // Divider model: on each start it answers after the latency chosen for that request
   initial begin
      int          rem = 0;
      bit          pending = 0;
      logic [31:0] op = '0;
      logic        prevStart = 1'b0;
      int          lat;
      forever begin
         @(posedge clk);
         #1;
         div_valid = 1'b0;
         div_error = 1'b0;
         div_quot  = 16'h0000;
         if (!rst_n) begin
            pending   = 0;
            prevStart = 1'b0;
            continue;
         end
         if (prevStart) checkOutput("div_start_one_cycle", 64'(div_start), 64'd0);
         if (pending) begin
            rem--;
            if (rem == 0) begin
               pending = 0;
               checkOutput("div_operands_held", 64'({div_num, div_den}), 64'(op));
               div_valid = 1'b1;
               div_error = (op[15:0] == 16'h0000);
               div_quot  = divQuot(op[31:16], op[15:0]);
            end
         end
         if (div_start) begin
            if (latQ.size() == 0) begin
               checkOutput("unexpected_div_start", 64'd1, 64'd0);
               lat = 0;
               op  = '0;
            end else begin
               lat = latQ.pop_front();
               op  = opQ.pop_front();
               checkOutput("div_operands_at_start", 64'({div_num, div_den}), 64'(op));
            end
            riseQ.push_back(cyc + (respondsInTime(lat) ? lat + 1 : TIMEOUT + 1));
            if (respondsInTime(lat)) begin
               pending = 1;
               rem     = lat;
            end
         end
         prevStart = div_start;
      end
   end

   // Randomized response backpressure when enabled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) rsp_ready = ($urandom % 4) != 0;
      end
   end

   // Monitor: timing of each new response, stability while stalled, content on handshake
   initial begin
      logic prevValid = 1'b0;
      logic prevHs    = 1'b0;
      exp_t prevRsp   = '0;
      exp_t cur;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevValid = 1'b0;
            prevHs    = 1'b0;
            continue;
         end
         cur = '{quot: rsp_quot, tag: rsp_tag, e0: rsp_err_div0, et: rsp_err_timeout};
         if (rsp_valid && (!prevValid || prevHs)) begin
            if (riseQ.size() == 0) checkOutput("unexpected_rsp_rise", 64'd1, 64'd0);
            else checkOutput("rsp_valid_cycle", 64'(cyc), 64'(riseQ.pop_front()));
         end else if (rsp_valid && prevValid && !prevHs) begin
            checkOutput("rsp_stable_while_stalled", 64'(cur), 64'(prevRsp));
         end
         if (rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_rsp", 64'(cur), 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rsp_content", 64'(cur), 64'(e));
            end
         end
         prevRsp   = cur;
         prevValid = rsp_valid;
         prevHs    = rsp_valid && rsp_ready;
      end
   end

   // Stimulus sequence
   initial begin
      int          accepted;
      int          cycles;
      int          curLat;
      logic [15:0] den;

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checkIdleOutputs("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single request 2.0/1.0");
      rsp_ready = 1'b1;
      applyStimulus(16'h2000, Q4_12_ONE, 4'd3, 7);
      waitDrained("single");

      $display("[TB] divide by zero");
      applyStimulus(16'h1234, 16'h0000, 4'd5, 3);
      waitDrained("div0");

      $display("[TB] backpressure with tags 0..7");
      rsp_ready = 1'b0;
      accepted  = 0;
      cycles    = 0;
      curLat    = $urandom_range(1, TIMEOUT);
      req_num   = 16'($urandom);
      req_den   = 16'($urandom_range(1, 16'hffff));
      req_tag   = '0;
      req_valid = 1'b1;
      while ((accepted < 8 || cycles <= 30) && cycles < 300) begin
         @(negedge clk);
         if (req_valid && req_ready) begin
            enqueue(req_num, req_den, req_tag, curLat);
            accepted++;
         end
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 30) begin
            checkOutput("accepts_before_full", 64'(accepted), 64'(DEPTH + 1));
            checkOutput("req_ready_when_full", 64'(req_ready), 64'd0);
            checkOutput("busy_when_full", 64'(busy), 64'd1);
            rsp_ready = 1'b1;
         end
         if (accepted >= 8) begin
            req_valid = 1'b0;
         end else if (req_tag != TAG_W'(accepted)) begin
            curLat  = $urandom_range(1, TIMEOUT);
            req_num = 16'($urandom);
            req_den = 16'($urandom_range(1, 16'hffff));
            req_tag = TAG_W'(accepted);
         end
      end
      req_valid = 1'b0;
      waitDrained("stream");

      $display("[TB] watchdog expiry then normal request");
      applyStimulus(16'h0800, 16'h0400, 4'd9, 0);
      applyStimulus(16'h3000, 16'h2000, 4'd10, 5);
      waitDrained("timeout");

      $display("[TB] result coincident with watchdog limit");
      applyStimulus(16'h1000, 16'h0800, 4'd11, TIMEOUT);
      waitDrained("coincident");

      $display("[TB] randomized traffic");
      randReady = 1'b1;
      for (int i = 0; i < 24; i++) begin
         den = (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom);
         curLat = (($urandom % 10) == 0) ? 0 : $urandom_range(1, TIMEOUT);
         applyStimulus(16'($urandom), den, TAG_W'($urandom), curLat);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      waitDrained("random");
      randReady = 1'b0;
      rsp_ready = 1'b1;

      $display("[TB] reset during WAIT with two queued");
      applyStimulus(16'h1111, 16'h0100, 4'd1, 0);
      applyStimulus(16'h2222, 16'h0200, 4'd2, 2);
      applyStimulus(16'h3333, 16'h0300, 4'd3, 2);
      checkOutput("pre_reset_busy", 64'(busy), 64'd1);
      checkOutput("pre_reset_in_flight_num", 64'(div_num), 64'h1111);
      checkOutput("pre_reset_rsp_valid", 64'(rsp_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("mid_reset");
      expQ.delete();
      latQ.delete();
      opQ.delete();
      riseQ.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      checkIdleOutputs("after_reset");
      applyStimulus(16'h1800, 16'h0800, 4'd6, 4);
      waitDrained("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
